// File: rtl/audio_onset_detector.sv
// Audio onset detector: pops ADC sample pairs, forms a mono magnitude and a
// peak-decay envelope, and pulses onset on threshold crossings with hold-off and hysteresis.
module audio_onset_detector #(
  parameter logic [31:0] THRESHOLD       = 32'd40000000,
  parameter logic [15:0] HOLDOFF_SAMPLES = 16'd12000,
  parameter int unsigned DECAY_SHIFT     = 6
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        enable,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic        onset,
  output logic [7:0]  onset_count,
  output logic [31:0] envelope,
  output logic        armed
);

  typedef enum logic [1:0] {ARMED, HOLD, WAIT_LOW} state_t;

  // A hold-off of zero behaves like one sample of hold-off.
  localparam logic [15:0] HOLD_LOAD = (HOLDOFF_SAMPLES == 16'd0) ? 16'd0 : HOLDOFF_SAMPLES - 16'd1;
  localparam logic [31:0] LOW_LEVEL = THRESHOLD >> 1;

  logic               read_q;
  logic signed [31:0] mono;
  logic [31:0]        mag;
  logic [31:0]        mag_q;
  logic               s1_valid;
  logic [31:0]        decayed;
  logic [31:0]        env_next;
  state_t             state_q, state_d;
  logic [15:0]        hold_cnt, hold_d;
  logic               fire;

  assign read_audio_in = audio_in_available & enable & ~read_q;
  assign armed         = (state_q == ARMED);

  // Halving each channel before the sum keeps mono inside 32 bits; only -2^31 needs saturation.
  always_comb begin
    mono = ($signed(left_channel_audio_in) >>> 1) + ($signed(right_channel_audio_in) >>> 1);
    if (mono == 32'sh8000_0000) mag = 32'h7FFF_FFFF;
    else if (mono[31])          mag = 32'(-mono);
    else                        mag = 32'(mono);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      read_q   <= 1'b0;
      s1_valid <= 1'b0;
      mag_q    <= '0;
    end else begin
      read_q   <= read_audio_in;
      // The strobe already includes enable, so disabling drops the in-flight sample.
      s1_valid <= read_audio_in;
      if (read_audio_in) mag_q <= mag;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    decayed  = envelope - (envelope >> DECAY_SHIFT);
    env_next = (mag_q > decayed) ? mag_q : decayed;
    state_d  = state_q;
    hold_d   = hold_cnt;
    fire     = 1'b0;
    if (s1_valid) begin
      case (state_q)
        ARMED: begin
          if (env_next >= THRESHOLD) begin
            fire    = 1'b1;
            hold_d  = HOLD_LOAD;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == 16'd0) state_d = WAIT_LOW;
          else                   hold_d  = hold_cnt - 16'd1;
        end
        WAIT_LOW: begin
          if (env_next < LOW_LEVEL) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ARMED;
      hold_cnt    <= '0;
      envelope    <= '0;
      onset       <= 1'b0;
      onset_count <= '0;
    end else if (!enable) begin
      // Disable overrides any stage-2 sample on the same edge; the count is kept.
      state_q  <= ARMED;
      hold_cnt <= '0;
      envelope <= '0;
      onset    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_d;
      onset    <= fire;
      if (s1_valid) envelope    <= env_next;
      if (fire)     onset_count <= onset_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_onset_detector.sv
// Self-checking bench for audio_onset_detector: a sample-queue reference model
// predicts every output each cycle; scenario tasks add targeted checks.
module tb_audio_onset_detector;

  localparam logic [31:0] TH = 32'd1000;
  localparam logic [15:0] HO = 16'd4;
  localparam int          DS = 2;

  localparam int PH_ARMED = 0;
  localparam int PH_HOLD  = 1;
  localparam int PH_WAIT  = 2;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        enable;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        onset;
  logic [7:0]  onset_count;
  logic [31:0] envelope;
  logic        armed;

  audio_onset_detector #(
    .THRESHOLD      (TH),
    .HOLDOFF_SAMPLES(HO),
    .DECAY_SHIFT    (DS)
  ) dut (
    .CLOCK_50              (CLOCK_50),
    .resetn                (resetn),
    .enable                (enable),
    .audio_in_available    (audio_in_available),
    .left_channel_audio_in (left_channel_audio_in),
    .right_channel_audio_in(right_channel_audio_in),
    .read_audio_in         (read_audio_in),
    .onset                 (onset),
    .onset_count           (onset_count),
    .envelope              (envelope),
    .armed                 (armed)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic        read;
    logic        onset;
    logic [7:0]  count;
    logic [31:0] env;
    logic        armed;
  } obs_t;

  typedef struct {
    int     due;
    longint mag;
  } pend_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  obs_t act;
  obs_t exp_o;
  bit   processed;

  // Reference model: a queue of magnitudes due two edges after their read.
  pend_t  pend[$];
  bit     m_read_q;
  longint m_env;
  int     m_count;
  int     m_phase;
  int     m_ignore;
  bit     m_onset;

  function automatic string fmt(obs_t o);
    return $sformatf("rd=%0b on=%0b cnt=%0d env=%0d arm=%0b", o.read, o.onset, o.count, o.env, o.armed);
  endfunction

  function automatic longint floor_half(longint x);
    return (x < 0) ? -((-x + 1) / 2) : x / 2;
  endfunction

  function automatic longint model_mag(logic [31:0] l, logic [31:0] r);
    longint mono = floor_half(longint'($signed(l))) + floor_half(longint'($signed(r)));
    longint m    = (mono < 0) ? -mono : mono;
    return (m > 64'sd2147483647) ? 64'sd2147483647 : m;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_read_q = 1'b0;
    m_env    = 0;
    m_count  = 0;
    m_phase  = PH_ARMED;
    m_ignore = 0;
    m_onset  = 1'b0;
  endtask

  task automatic model_sample(longint mag);
    longint decayed = m_env - m_env / (64'sd1 << DS);
    m_env = (mag > decayed) ? mag : decayed;
    case (m_phase)
      PH_ARMED: if (m_env >= longint'(TH)) begin
        m_onset  = 1'b1;
        m_count  = (m_count + 1) % 256;
        m_ignore = (HO == 16'd0) ? 1 : int'(HO);
        m_phase  = PH_HOLD;
      end
      PH_HOLD: begin
        m_ignore--;
        if (m_ignore == 0) m_phase = PH_WAIT;
      end
      default: if (m_env < longint'(TH) / 2) m_phase = PH_ARMED;
    endcase
  endtask

  // Advance one clock: sample the strobe before the edge, update the model, sample registers after.
  task automatic step();
    bit    r;
    pend_t p;
    #1;
    r        = audio_in_available & enable & ~m_read_q;
    act.read = read_audio_in;
    @(posedge CLOCK_50);
    cyc++;
    m_onset   = 1'b0;
    processed = 1'b0;
    if (!enable) begin
      pend.delete();
      m_env    = 0;
      m_phase  = PH_ARMED;
      m_ignore = 0;
    end else begin
      if (pend.size() != 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        model_sample(p.mag);
        processed = 1'b1;
      end
      if (r) pend.push_back('{due: cyc + 1, mag: model_mag(left_channel_audio_in, right_channel_audio_in)});
    end
    m_read_q = r;
    #1;
    act.onset   = onset;
    act.count   = onset_count;
    act.env     = envelope;
    act.armed   = armed;
    exp_o.read  = r;
    exp_o.onset = m_onset;
    exp_o.count = m_count[7:0];
    exp_o.env   = m_env[31:0];
    exp_o.armed = (m_phase == PH_ARMED);
  endtask

  task automatic do_reset();
    enable             = 1'b0;
    audio_in_available = 1'b0;
    resetn             = 1'b0;
    model_reset();
    @(posedge CLOCK_50);
    #2 resetn = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    enable             = 1'b1;
    audio_in_available = 1'b1;
    for (int c = 0; c < 20; c++) begin
      left_channel_audio_in  = 32'($urandom_range(0, 6000)) - 32'd3000;
      right_channel_audio_in = 32'($urandom_range(0, 6000)) - 32'd3000;
      step();
      total++;
      if (act !== exp_o) begin bad++; $display("FAIL reset_pre cyc=%0d got %s want %s", cyc, fmt(act), fmt(exp_o)); end
    end
    #2;
    resetn = 1'b0;
    enable = 1'b0;
    model_reset();
    #1;
    total++;
    if ({read_audio_in, onset, onset_count, envelope, armed} !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_async got rd=%0b on=%0b cnt=%0d env=%0d arm=%0b want 0 0 0 0 1",
               read_audio_in, onset, onset_count, envelope, armed);
    end
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #2 resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (act !== 45'({1'b0, 1'b0, 8'd0, 32'd0, 1'b1})) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got %s want rd=0 on=0 cnt=0 env=0 arm=1", cyc, fmt(act));
      end
    end
  endtask

  task automatic test_single_clap();
    int     lv[$];
    int     idx = 0;
    int     rc = -10;
    int     pulses = 0;
    logic [31:0] envs[$];
    logic [31:0] want[4] = '{32'd3000, 32'd2250, 32'd1688, 32'd1266};
    do_reset();
    lv.push_back(0);
    lv.push_back(3000);
    for (int i = 0; i < 20; i++) lv.push_back(0);
    audio_in_available     = 1'b1;
    left_channel_audio_in  = lv[0];
    right_channel_audio_in = lv[0];
    for (int c = 0; c < 200 && idx < lv.size(); c++) begin
      step();
      total++;
      if (act !== exp_o) begin bad++; $display("FAIL clap cyc=%0d got %s want %s", cyc, fmt(act), fmt(exp_o)); end
      if (act.onset) pulses++;
      if (processed) envs.push_back(act.env);
      if (cyc == rc + 1) begin
        total++;
        if (act.onset !== 1'b1 || act.env !== 32'd3000) begin
          bad++;
          $display("FAIL clap_latency got on=%0b env=%0d want on=1 env=3000", act.onset, act.env);
        end
      end
      if (exp_o.read) begin
        if (idx == 1) rc = cyc;
        idx++;
        if (idx < lv.size()) begin
          left_channel_audio_in  = lv[idx];
          right_channel_audio_in = lv[idx];
        end
      end
    end
    audio_in_available = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (act.onset) pulses++;
    end
    total++;
    if (idx < lv.size()) begin bad++; $display("FAIL clap_timeout got %0d reads want %0d", idx, lv.size()); end
    total++;
    if (pulses != 1 || act.count !== 8'd1) begin
      bad++;
      $display("FAIL clap_count got pulses=%0d cnt=%0d want 1 1", pulses, act.count);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (envs.size() < 5 || envs[i + 1] !== want[i]) begin
        bad++;
        $display("FAIL clap_decay[%0d] got %0d want %0d", i, (envs.size() < 5) ? 32'd0 : envs[i + 1], want[i]);
      end
    end
  endtask

  task automatic test_hysteresis();
    int lv[$];
    int idx = 0;
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 12; i++) lv.push_back(2000);
    for (int i = 0; i < 8; i++)  lv.push_back(0);
    lv.push_back(2000);
    lv.push_back(2000);
    audio_in_available     = 1'b1;
    left_channel_audio_in  = lv[0];
    right_channel_audio_in = lv[0];
    for (int c = 0; c < 200 && idx < lv.size(); c++) begin
      step();
      total++;
      if (act !== exp_o) begin bad++; $display("FAIL hyst cyc=%0d got %s want %s", cyc, fmt(act), fmt(exp_o)); end
      if (act.onset) pulses++;
      if (exp_o.read) begin
        idx++;
        if (idx == 12) begin
          total++;
          if (act.armed !== 1'b0 || pulses != 1) begin
            bad++;
            $display("FAIL hyst_holdoff got arm=%0b pulses=%0d want arm=0 pulses=1", act.armed, pulses);
          end
        end
        if (idx < lv.size()) begin
          left_channel_audio_in  = lv[idx];
          right_channel_audio_in = lv[idx];
        end
      end
    end
    audio_in_available = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (act.onset) pulses++;
    end
    total++;
    if (pulses != 2 || act.count !== 8'd2) begin
      bad++;
      $display("FAIL hyst_rearm got pulses=%0d cnt=%0d want 2 2", pulses, act.count);
    end
  endtask

  task automatic test_saturation();
    bit seen = 1'b0;
    do_reset();
    audio_in_available     = 1'b1;
    left_channel_audio_in  = 32'h8000_0000;
    right_channel_audio_in = 32'h8000_0000;
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if (act !== exp_o) begin bad++; $display("FAIL sat cyc=%0d got %s want %s", cyc, fmt(act), fmt(exp_o)); end
      if (exp_o.read) audio_in_available = 1'b0;
      if (processed && !seen) begin
        seen = 1'b1;
        total++;
        if (act.env !== 32'h7FFF_FFFF || act.onset !== 1'b1) begin
          bad++;
          $display("FAIL sat_env got env=%h on=%0b want env=7fffffff on=1", act.env, act.onset);
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL sat_timeout got no sample want one"); end
  endtask

  task automatic test_count_wrap();
    int pulses = 0;
    do_reset();
    audio_in_available = 1'b1;
    for (int c = 0; c < 20000 && pulses < 256; c++) begin
      left_channel_audio_in  = (m_phase == PH_ARMED) ? 32'd3000 : 32'd0;
      right_channel_audio_in = left_channel_audio_in;
      step();
      total++;
      if (act !== exp_o) begin bad++; $display("FAIL wrap cyc=%0d got %s want %s", cyc, fmt(act), fmt(exp_o)); end
      if (act.onset) begin
        pulses++;
        if (pulses == 255 || pulses == 256) begin
          total++;
          if (act.count !== 8'(pulses)) begin
            bad++;
            $display("FAIL wrap_count after %0d onsets got %0d want %0d", pulses, act.count, 8'(pulses));
          end
        end
      end
    end
    total++;
    if (pulses != 256) begin bad++; $display("FAIL wrap_timeout got %0d onsets want 256", pulses); end
    audio_in_available = 1'b0;
  endtask

  task automatic test_handshake();
    audio_in_available = 1'b0;
    step();
    audio_in_available     = 1'b1;
    left_channel_audio_in  = 32'd10;
    right_channel_audio_in = 32'd10;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (act.read !== (i % 2 == 0) || act !== exp_o) begin
        bad++;
        $display("FAIL handshake[%0d] got %s want rd=%0b %s", i, fmt(act), (i % 2 == 0), fmt(exp_o));
      end
    end
    audio_in_available = 1'b0;
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic test_disable_mid();
    int lv[2] = '{500, 3000};
    int idx = 0;
    do_reset();
    audio_in_available     = 1'b1;
    left_channel_audio_in  = lv[0];
    right_channel_audio_in = lv[0];
    for (int c = 0; c < 20 && idx < 2; c++) begin
      step();
      if (exp_o.read) begin
        idx++;
        if (idx < 2) begin
          left_channel_audio_in  = lv[idx];
          right_channel_audio_in = lv[idx];
        end
      end
    end
    total++;
    if (idx < 2 || act.env !== 32'd500) begin
      bad++;
      $display("FAIL dis_setup got reads=%0d env=%0d want 2 500", idx, act.env);
    end
    audio_in_available = 1'b0;
    enable             = 1'b0;
    step();
    total++;
    if (act.onset !== 1'b0 || act.count !== 8'd0 || act.env !== 32'd0 || act.armed !== 1'b1 || act !== exp_o) begin
      bad++;
      $display("FAIL dis_mid got %s want rd=0 on=0 cnt=0 env=0 arm=1", fmt(act));
    end
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (act.onset !== 1'b0 || act.count !== 8'd0 || act !== exp_o) begin
        bad++;
        $display("FAIL dis_after cyc=%0d got %s want %s", cyc, fmt(act), fmt(exp_o));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      audio_in_available = ($urandom_range(0, 3) != 0);
      enable             = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 7))
        0:       left_channel_audio_in = 32'h8000_0000;
        1:       left_channel_audio_in = $urandom();
        default: left_channel_audio_in = 32'($urandom_range(0, 8000)) - 32'd4000;
      endcase
      case ($urandom_range(0, 7))
        0:       right_channel_audio_in = 32'h8000_0001;
        1:       right_channel_audio_in = $urandom();
        default: right_channel_audio_in = 32'($urandom_range(0, 8000)) - 32'd4000;
      endcase
      step();
      total++;
      if (act !== exp_o) begin bad++; $display("FAIL random cyc=%0d got %s want %s", cyc, fmt(act), fmt(exp_o)); end
    end
    enable = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn                 = 1'b0;
    enable                 = 1'b0;
    audio_in_available     = 1'b0;
    left_channel_audio_in  = '0;
    right_channel_audio_in = '0;
    act                    = '0;
    exp_o                  = '0;
    model_reset();
    #12 resetn = 1'b1;
    test_reset();
    test_single_clap();
    test_hysteresis();
    test_saturation();
    test_handshake();
    test_disable_mid();
    test_count_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_onset_detector.md
# audio_onset_detector

Microphone-side consumer of the Audio_Controller ADC sample stream for the dance game. It pops left/right input samples through the controller's read handshake and forms a mono magnitude and a peak-decay envelope. It emits a one-cycle onset pulse when the envelope crosses a threshold, for example on a stomp or clap, with hold-off and hysteresis against retriggering. It sits beside the countdown/beep generator and feeds the step-scoring logic and the LEDs.

## Interface
- THRESHOLD, 32'd40000000: envelope level that fires an onset (unsigned).
- HOLDOFF_SAMPLES, 16'd12000: samples ignored after an onset (0.25 s at 48 kHz).
- DECAY_SHIFT, 6: envelope decay rate; per sample, env loses env>>DECAY_SHIFT. Legal values are 1..15.
- CLOCK_50  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  detector run (driven from SW[0]).
- audio_in_available  in  1  controller has an input sample pair ready.
- left_channel_audio_in  in  32  signed left sample; valid while available=1.
- right_channel_audio_in  in  32  signed right sample; valid while available=1.
- read_audio_in  out  1  one-cycle pop strobe to the controller.
- onset  out  1  one-cycle pulse per detected onset.
- onset_count  out  8  onsets since reset; wraps.
- envelope  out  32  current envelope (unsigned, ≤ 2^31-1).
- armed  out  1  high while the FSM is in ARMED (LED drive).

## Operation
- Fetch: read_audio_in = audio_in_available & enable & ~read_q, where read_q is read_audio_in registered. The strobe is never high on two consecutive cycles. L and R are captured at the edge that ends the read cycle.
- Stage 1, mono: mono = (L>>>1) + (R>>>1), signed 32-bit with no overflow. mag = |mono|. If mono = -2^31, mag saturates to 2^31-1.
- Stage 2, envelope: env_next = max(mag, env - (env>>DECAY_SHIFT)), unsigned, registered into envelope. The FSM and the counter update on the same edge, using env_next.
- FSM with states ARMED, HOLD and WAIT_LOW. Transitions are evaluated only on edges where stage 2 processes a sample.
  - ARMED: if env_next ≥ THRESHOLD, then set onset=1, increment onset_count, load hold_cnt=HOLDOFF_SAMPLES-1 and go to HOLD.
  - HOLD: if hold_cnt==0, go to WAIT_LOW; otherwise decrement hold_cnt. No onset is possible in HOLD.
  - WAIT_LOW: if env_next < (THRESHOLD>>1), go to ARMED.
- HOLDOFF_SAMPLES = 0 is treated as 1.
- onset_count increments modulo 256, so 255 becomes 0.
- enable low:
  - read_audio_in = 0.
  - Pipeline valid bits are cleared, so an in-flight sample is dropped.
  - envelope is cleared to 0 and the FSM goes to ARMED.
  - onset is forced to 0.
  - onset_count holds its value.
- Reset (asynchronous, any time, including mid-pipeline) sets these values: read_q=0, onset=0, onset_count=0, envelope=0, FSM=ARMED (so armed=1), hold_cnt=0, and all pipeline valids to 0.

## Timing
- Throughput is at most one sample per 2 cycles. The controller delivers about 48 kHz, so this never limits.
- Latency, with read_audio_in high in cycle N:
  - mag is valid in cycle N+1.
  - envelope, FSM state and onset_count are updated in cycle N+2.
  - onset is high for exactly cycle N+2.
- onset is high for exactly 1 cycle per onset, and always 0 on cycles with no stage-2 sample.
- Simultaneous events:
  - enable deassert wins over a stage-2 sample in the same cycle: no onset, no count.
  - A new read may occur in the same cycle as stage-1 or stage-2 work; there are no stalls.
- audio_in_available dropping while read_q=1 has no effect. The data were captured on the read edge.

## Test plan
- Reset and idle: hold resetn=0 mid-stream, then release with enable=0, available=1. Required: read_audio_in stays 0, onset=0, count=0, envelope=0, armed=1.
- Single clap, with THRESHOLD=1000, HOLDOFF_SAMPLES=4, DECAY_SHIFT=2.
  - Stimulus: samples (0,0),(3000,3000),(0,0)×20.
  - Required: exactly one onset, 2 cycles after the read of (3000,3000); envelope=3000 in that cycle; count=1; then envelope values 2250, 1688, 1266…
- Hold-off and hysteresis, with the same parameters.
  - Stimulus: 2000 in every sample.
  - Required: one onset only, then FSM goes HOLD → WAIT_LOW and stays there while env ≥ 500.
  - Then zero samples until env < 500, and 2000 again. Required: a second onset; count=2.
- Saturation: L=R=-2^31. Required: mono=-2^31, mag=envelope=2^31-1, no wrap. Count wrap: 256 onsets take count 255 → 0.
- Handshake: hold available=1 continuously. Required: read_audio_in toggles 1,0,1,0.
- Disable mid-pipeline: enable→0 in the cycle after a threshold-crossing read. Required: no onset, count unchanged, envelope=0 next cycle.
